// File: rtl/bf_io_pkg.sv
// Shared encodings and defaults for the interpreter I/O responder:
// output/input handshake state encodings and UART framing constants.
package bf_io_pkg;

  typedef enum logic [2:0] {
    O_IDLE  = 3'd0,
    O_START = 3'd1,
    O_DATA  = 3'd2,
    O_STOP  = 3'd3,
    O_ACK   = 3'd4
  } out_state_t;

  typedef enum logic {
    I_WAIT = 1'b0,
    I_DONE = 1'b1
  } in_state_t;

  // 50 MHz clock: 115200 baud and a 10 ms debounce window.
  localparam int CLKS_PER_BIT_DEFAULT    = 434;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;

  // Start bit + 8 data bits + stop bit.
  localparam int FRAME_BITS = 10;

endpackage

// File: rtl/bf_debounce.sv
// Button conditioner: 2-flop synchroniser followed by a stability counter;
// emits the accepted level and a one-cycle pulse on its rising edge.
module bf_debounce #(
  parameter int DEBOUNCE_CYCLES = bf_io_pkg::DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic clean,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;

  // NOTE: every flop here is sequential state, so all updates are non-blocking and
  // the reset is sampled on the clock edge (synchronous), matching the rest of the codebase.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync  <= '0;
      cnt   <= '0;
      clean <= 1'b0;
      rise  <= 1'b0;
    end else begin
      // raw is asynchronous; only sync[1] is allowed to feed any logic.
      sync <= {sync[0], raw};
      rise <= 1'b0;
      if (sync[1] == clean) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        cnt   <= '0;
        clean <= ~clean;
        rise  <= ~clean;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/bf_io_responder.sv
// I/O responder for the interpreter's '.' and ',' four-phase handshakes:
// 8N1 UART transmitter on the output side, debounced "enter" button on the input side.
module bf_io_responder
  import bf_io_pkg::*;
#(
  parameter int CLKS_PER_BIT    = CLKS_PER_BIT_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       out_req,
  input  logic [7:0] out_data,
  output logic       out_done,
  output logic       tx,
  output logic       tx_busy,
  output logic [7:0] last_out,
  input  logic       in_req,
  input  logic       in_btn,
  output logic       in_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  out_state_t       o_state, o_state_d;
  logic [7:0]       shift_reg, shift_d;
  logic [2:0]       bit_cnt, bit_d;
  logic [BAUD_W-1:0] baud_cnt, baud_d;
  logic             tx_d, busy_d, out_done_d;
  logic [7:0]       last_d;
  logic             baud_end;

  in_state_t        i_state, i_state_d;
  logic             btn_clean, btn_rise;

  assign baud_end = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));

  // NOTE: every variable written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    o_state_d  = o_state;
    shift_d    = shift_reg;
    bit_d      = bit_cnt;
    baud_d     = baud_cnt;
    tx_d       = tx;
    busy_d     = tx_busy;
    out_done_d = out_done;
    last_d     = last_out;
    unique case (o_state)
      O_IDLE: begin
        if (out_req) begin
          o_state_d = O_START;
          shift_d   = out_data;
          last_d    = out_data;
          bit_d     = '0;
          baud_d    = '0;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
        end
      end
      O_START: begin
        if (baud_end) begin
          baud_d    = '0;
          o_state_d = O_DATA;
          tx_d      = shift_reg[0];
        end else begin
          baud_d = baud_cnt + 1'b1;
        end
      end
      O_DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = shift_reg >> 1;
          if (bit_cnt == 3'd7) begin
            o_state_d = O_STOP;
            tx_d      = 1'b1;
          end else begin
            // Present the next LSB in the same edge as the shift.
            bit_d = bit_cnt + 3'd1;
            tx_d  = shift_reg[1];
          end
        end else begin
          baud_d = baud_cnt + 1'b1;
        end
      end
      O_STOP: begin
        if (baud_end) begin
          baud_d     = '0;
          o_state_d  = O_ACK;
          busy_d     = 1'b0;
          out_done_d = 1'b1;
        end else begin
          baud_d = baud_cnt + 1'b1;
        end
      end
      O_ACK: begin
        if (!out_req) begin
          o_state_d  = O_IDLE;
          out_done_d = 1'b0;
        end
      end
      default: o_state_d = O_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      o_state   <= O_IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      baud_cnt  <= '0;
      tx        <= 1'b1;
      tx_busy   <= 1'b0;
      out_done  <= 1'b0;
      last_out  <= '0;
    end else begin
      o_state   <= o_state_d;
      shift_reg <= shift_d;
      bit_cnt   <= bit_d;
      baud_cnt  <= baud_d;
      tx        <= tx_d;
      tx_busy   <= busy_d;
      out_done  <= out_done_d;
      last_out  <= last_d;
    end
  end

  bf_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk  (clk),
    .reset(reset),
    .raw  (in_btn),
    .clean(btn_clean),
    .rise (btn_rise)
  );

  // A press only counts as a fresh edge seen while the request is up; the ack
  // holds until both the request is dropped and the button is released.
  always_comb begin
    i_state_d = i_state;
    unique case (i_state)
      I_WAIT:  if (in_req && btn_rise) i_state_d = I_DONE;
      I_DONE:  if (!in_req && !btn_clean) i_state_d = I_WAIT;
      default: i_state_d = I_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      i_state <= I_WAIT;
      in_done <= 1'b0;
    end else begin
      i_state <= i_state_d;
      in_done <= (i_state_d == I_DONE);
    end
  end

endmodule

// File: tb/tb_bf_io_responder.sv
// Directed bench for bf_io_responder: table of UART frames plus hand-written
// reset, debounce and concurrent-handshake sequences (CLKS_PER_BIT=4, DEBOUNCE_CYCLES=8).
module tb_bf_io_responder;
  import bf_io_pkg::*;

  localparam int CPB = 4;
  localparam int DEB = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       out_req;
  logic [7:0] out_data;
  logic       out_done;
  logic       tx;
  logic       tx_busy;
  logic [7:0] last_out;
  logic       in_req;
  logic       in_btn;
  logic       in_done;

  int n_vec  = 0;
  int n_fail = 0;

  bf_io_responder #(
    .CLKS_PER_BIT   (CPB),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .out_req (out_req),
    .out_data(out_data),
    .out_done(out_done),
    .tx      (tx),
    .tx_busy (tx_busy),
    .last_out(last_out),
    .in_req  (in_req),
    .in_btn  (in_btn),
    .in_done (in_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;   // bit 0 = start bit, bit 9 = stop bit
    int         chg_at;  // cycle at which out_data is changed to 8'hFF (-1: never)
    int         btn_at;  // cycle at which the button is pressed (-1: never)
    int         hold;    // cycles out_req stays high after out_done
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends one frame starting from O_IDLE; k counts edges after acceptance edge E.
  task automatic run_frame(input vec_t v);
    logic bad;
    out_data = v.data;
    out_req  = 1'b1;
    tick();
    for (int k = 0; k <= FRAME_BITS * CPB; k++) begin
      if (k == 0) begin
        check("tx_start_fall", tx, 0);
        check("busy_on", tx_busy, 1);
        check("last_out_load", last_out, v.data);
      end
      if (k < FRAME_BITS * CPB && (k % CPB) == 2)
        check($sformatf("tx_bit%0d_of_%h", k / CPB, v.data), tx, v.frame[k / CPB]);
      if (k == FRAME_BITS * CPB - 1) check("done_early", out_done, 0);
      if (k == FRAME_BITS * CPB) begin
        check("done_rise", out_done, 1);
        check("busy_off", tx_busy, 0);
        check("tx_idle", tx, 1);
        check("last_out_hold", last_out, v.data);
      end
      if (v.chg_at >= 0 && k == v.chg_at) out_data = 8'hFF;
      if (v.btn_at >= 0) begin
        if (k == v.btn_at) in_btn = 1'b1;
        if (k == v.btn_at + 10) check("in_done_early", in_done, 0);
        if (k == v.btn_at + 11) check("in_done_rise", in_done, 1);
      end
      if (k < FRAME_BITS * CPB) tick();
    end
    if (v.hold > 0) begin
      bad = 1'b0;
      for (int h = 0; h < v.hold; h++) begin
        tick();
        if (out_done !== 1'b1 || tx_busy !== 1'b0 || tx !== 1'b1) bad = 1'b1;
      end
      check("no_refire_while_req_high", bad, 0);
    end
    out_req = 1'b0;
    tick();
    check("done_fall", out_done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[4];
    vec_t v;
    logic bad;

    vecs[0] = '{data: 8'h41, frame: 10'h282, chg_at: -1, btn_at: -1, hold: 0};
    vecs[1] = '{data: 8'h41, frame: 10'h282, chg_at: 10, btn_at: -1, hold: 8};
    vecs[2] = '{data: 8'hFF, frame: 10'h3FE, chg_at: -1, btn_at: -1, hold: 0};
    vecs[3] = '{data: 8'h00, frame: 10'h200, chg_at: -1, btn_at: -1, hold: 0};

    reset = 1'b1; out_req = 1'b0; out_data = 8'h00; in_req = 1'b0; in_btn = 1'b0;
    repeat (3) tick();
    check("rst_tx", tx, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_out_done", out_done, 0);
    check("rst_last_out", last_out, 0);
    check("rst_in_done", in_done, 0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) run_frame(vecs[i]);

    // Reset in the middle of the data bits aborts the frame.
    out_data = 8'hC3;
    out_req  = 1'b1;
    tick();
    repeat (15) tick();
    check("mid_frame_busy", tx_busy, 1);
    reset   = 1'b1;
    out_req = 1'b0;
    tick();
    check("abort_tx", tx, 1);
    check("abort_busy", tx_busy, 0);
    check("abort_done", out_done, 0);
    check("abort_last_out", last_out, 0);
    reset = 1'b0;
    tick();
    v = '{data: 8'hA5, frame: 10'h34A, chg_at: -1, btn_at: -1, hold: 0};
    run_frame(v);

    // Bouncing button must not be accepted; a stable high is.
    in_req = 1'b1;
    bad = 1'b0;
    for (int s = 0; s < 10; s++) begin
      in_btn = (s % 2 == 0);
      repeat (3) begin
        tick();
        if (in_done !== 1'b0) bad = 1'b1;
      end
    end
    check("bounce_no_ack", bad, 0);
    in_btn = 1'b1;
    repeat (10) tick();
    check("stable_ack_early", in_done, 0);
    tick();
    check("stable_ack_rise", in_done, 1);
    in_req = 1'b0;
    in_btn = 1'b0;
    repeat (15) tick();
    check("stable_ack_clear", in_done, 0);

    // Press held before the request does not count; a fresh press does.
    in_btn = 1'b1;
    repeat (15) tick();
    in_req = 1'b1;
    bad = 1'b0;
    repeat (15) begin
      tick();
      if (in_done !== 1'b0) bad = 1'b1;
    end
    check("held_press_ignored", bad, 0);
    in_btn = 1'b0;
    repeat (15) tick();
    check("release_no_ack", in_done, 0);
    in_btn = 1'b1;
    repeat (10) tick();
    check("fresh_press_early", in_done, 0);
    tick();
    check("fresh_press_ack", in_done, 1);
    in_req = 1'b0;
    repeat (15) tick();
    check("ack_held_while_pressed", in_done, 1);
    in_btn = 1'b0;
    repeat (10) tick();
    check("ack_before_clean_low", in_done, 1);
    tick();
    check("ack_drop_after_release", in_done, 0);

    // Both channels at once; each keeps its own timing.
    in_req = 1'b1;
    v = '{data: 8'h5A, frame: 10'h2B4, chg_at: -1, btn_at: 5, hold: 0};
    run_frame(v);
    check("dual_in_done_held", in_done, 1);
    in_req = 1'b0;
    in_btn = 1'b0;
    repeat (15) tick();
    check("dual_in_done_clear", in_done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
